nbit_mux: RTL and testbench

NBIT_MUX -- requirements
Module: nbit_mux

---
 rtl/nbit_mux_if.sv | 28 ++
 rtl/nbit_mux.sv | 70 +++++++
 tb/tb_nbit_mux.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/nbit_mux_if.sv
// nbit_mux_if: groups the mux data/select/enable bus and its results.
// master drives candidates and select, slave returns out and sel_err.
interface nbit_mux_if #(
  parameter int SELECT_WIDTH = 1,
  parameter int NUM_INPUTS   = 2**SELECT_WIDTH
);
  logic [NUM_INPUTS-1:0]   data;
  logic [SELECT_WIDTH-1:0] select;
  logic                    en;
  logic                    out;
  logic                    sel_err;

  modport master (
    output data,
    output select,
    output en,
    input  out,
    input  sel_err
  );

  modport slave (
    input  data,
    input  select,
    input  en,
    output out,
    output sel_err
  );
endinterface

// File: rtl/nbit_mux.sv
// nbit_mux: 1-bit N:1 multiplexer with an out-of-range select flag.
// Define NBIT_MUX_REG_OUT_EN to register out/sel_err (en-gated, async clear).
module nbit_mux #(
  parameter int SELECT_WIDTH = 1,
  parameter int NUM_INPUTS   = 2**SELECT_WIDTH
) (
  input  logic [NUM_INPUTS-1:0]   data,
  output logic                    out,
  input  logic [SELECT_WIDTH-1:0] select,
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    sel_err
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 2**SELECT_WIDTH) begin : g_bad_cfg
    $error("nbit_mux: NUM_INPUTS must lie in 2..2**SELECT_WIDTH");
  end

  logic sel_val;
  logic err_val;

  // Route candidate[select]; out-of-range indices give 0 and raise the flag.
  always_comb begin
    sel_val = 1'b0;
    err_val = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (select == SELECT_WIDTH'(i)) begin
        sel_val = data[i];
        err_val = 1'b0;
      end
    end
  end

`ifdef NBIT_MUX_REG_OUT_EN
  logic out_q, out_d;
  logic err_q, err_d;

  // Capture the new selection only when enabled, else hold.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (en) begin
      out_d = sel_val;
      err_d = err_val;
    end
  end

  // Output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign out     = out_q;
  assign sel_err = err_q;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, en};

  assign out     = sel_val;
  assign sel_err = err_val;
`endif

endmodule

// File: tb/tb_nbit_mux.sv
// tb_nbit_mux: directed checks of nbit_mux in three configurations.
// Follows NBIT_MUX_REG_OUT_EN to pick combinational or registered vectors.
module tb_nbit_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  nbit_mux_if #(.SELECT_WIDTH(1)) b1 ();
  nbit_mux_if #(.SELECT_WIDTH(2)) b2 ();
  nbit_mux_if #(.SELECT_WIDTH(2), .NUM_INPUTS(3)) b3 ();

  nbit_mux #(.SELECT_WIDTH(1)) u1 (
    .data(b1.data), .out(b1.out), .select(b1.select), .clk(clk),
    .rst_n(rst_n), .en(b1.en), .sel_err(b1.sel_err)
  );

  nbit_mux #(.SELECT_WIDTH(2)) u2 (
    .data(b2.data), .out(b2.out), .select(b2.select), .clk(clk),
    .rst_n(rst_n), .en(b2.en), .sel_err(b2.sel_err)
  );

  nbit_mux #(.SELECT_WIDTH(2), .NUM_INPUTS(3)) u3 (
    .data(b3.data), .out(b3.out), .select(b3.select), .clk(clk),
    .rst_n(rst_n), .en(b3.en), .sel_err(b3.sel_err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    b1.data = '0; b1.select = '0; b1.en = 1'b0;
    b2.data = '0; b2.select = '0; b2.en = 1'b0;
    b3.data = '0; b3.select = '0; b3.en = 1'b0;

`ifdef NBIT_MUX_REG_OUT_EN
    // Reset holds everything at 0 even with enable and live data.
    b1.data = 2'b11; b1.select = 1'b1; b1.en = 1'b1;
    b3.select = 2'd3; b3.en = 1'b1;
    #12;
    chk("rst_out1", b1.out, 1'b0);
    chk("rst_err1", b1.sel_err, 1'b0);
    chk("rst_err3", b3.sel_err, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_out1", b1.out, 1'b0);
    chk("rst_hold_err3", b3.sel_err, 1'b0);

    // Release mid-cycle; en=0 at first edge must not capture.
    #2; rst_n = 1'b1;
    b1.en = 1'b0; b3.en = 1'b0;
    @(posedge clk); #1;
    chk("no_en_out1", b1.out, 1'b0);
    chk("no_en_err3", b3.sel_err, 1'b0);

    // data=01, select 1 then 0: 1-cycle latency, no comb path.
    b1.data = 2'b01; b1.select = 1'b1; b1.en = 1'b1;
    @(posedge clk); #1;
    chk("lat_sel1", b1.out, 1'b0);
    b1.select = 1'b0;
    #2;
    chk("lat_before_edge", b1.out, 1'b0);
    @(posedge clk); #1;
    chk("lat_after_edge", b1.out, 1'b1);
    chk("lat_err", b1.sel_err, 1'b0);

    // Hold with en=0 while select toggles for 3 cycles.
    b1.en = 1'b0;
    b1.select = 1'b1; @(posedge clk); #1;
    chk("hold_c1", b1.out, 1'b1);
    b1.select = 1'b0; @(posedge clk); #1;
    chk("hold_c2", b1.out, 1'b1);
    b1.select = 1'b1; @(posedge clk); #1;
    chk("hold_c3", b1.out, 1'b1);

    // 4-input sweep, data=1011 -> 1,1,0,1.
    b2.data = 4'b1011; b2.en = 1'b1;
    b2.select = 2'd0; @(posedge clk); #1;
    chk("sw_r_s0", b2.out, 1'b1);
    b2.select = 2'd1; @(posedge clk); #1;
    chk("sw_r_s1", b2.out, 1'b1);
    b2.select = 2'd2; @(posedge clk); #1;
    chk("sw_r_s2", b2.out, 1'b0);
    b2.select = 2'd3; @(posedge clk); #1;
    chk("sw_r_s3", b2.out, 1'b1);
    chk("sw_r_err", b2.sel_err, 1'b0);

    // 3-input: out-of-range registers err, en=0 holds it.
    b3.data = 3'b111; b3.select = 2'd3; b3.en = 1'b1;
    @(posedge clk); #1;
    chk("r3_oor_out", b3.out, 1'b0);
    chk("r3_oor_err", b3.sel_err, 1'b1);
    b3.select = 2'd2; b3.en = 1'b0;
    @(posedge clk); #1;
    chk("r3_hold_err", b3.sel_err, 1'b1);
    chk("r3_hold_out", b3.out, 1'b0);
    b3.en = 1'b1;
    @(posedge clk); #1;
    chk("r3_in_out", b3.out, 1'b1);
    chk("r3_in_err", b3.sel_err, 1'b0);

    // Get u1 out=1 and u3 err=1, then pulse reset between edges.
    b1.data = 2'b01; b1.select = 1'b0; b1.en = 1'b1;
    b3.select = 2'd3;
    @(posedge clk); #1;
    chk("pre_rst_out1", b1.out, 1'b1);
    chk("pre_rst_err3", b3.sel_err, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk("async_out1", b1.out, 1'b0);
    chk("async_err1", b1.sel_err, 1'b0);
    chk("async_err3", b3.sel_err, 1'b0);
    #1; rst_n = 1'b1;
    b3.en = 1'b0;
    #1;
    chk("post_rel_out1", b1.out, 1'b0);
    @(posedge clk); #1;
    chk("post_rel_edge", b1.out, 1'b1);
    chk("post_rel_err3", b3.sel_err, 1'b0);
`else
    rst_n = 1'b1;
    // 2-input, data=10.
    b1.data = 2'b10; b1.select = 1'b0; #1;
    chk("c1_s0", b1.out, 1'b0);
    chk("c1_s0_err", b1.sel_err, 1'b0);
    b1.select = 1'b1; #1;
    chk("c1_s1", b1.out, 1'b1);
    chk("c1_s1_err", b1.sel_err, 1'b0);
    b1.data = 2'b01; #1;
    chk("c1_data_chg", b1.out, 1'b0);

    // 4-input sweep, data=1011 -> 1,1,0,1.
    b2.data = 4'b1011;
    b2.select = 2'd0; #1; chk("c2_s0", b2.out, 1'b1);
    b2.select = 2'd1; #1; chk("c2_s1", b2.out, 1'b1);
    b2.select = 2'd2; #1; chk("c2_s2", b2.out, 1'b0);
    b2.select = 2'd3; #1; chk("c2_s3", b2.out, 1'b1);
    chk("c2_err", b2.sel_err, 1'b0);
    // 4-input sweep, data=0110 -> 0,1,1,0.
    b2.data = 4'b0110;
    b2.select = 2'd0; #1; chk("c2b_s0", b2.out, 1'b0);
    b2.select = 2'd1; #1; chk("c2b_s1", b2.out, 1'b1);
    b2.select = 2'd2; #1; chk("c2b_s2", b2.out, 1'b1);
    b2.select = 2'd3; #1; chk("c2b_s3", b2.out, 1'b0);

    // 3-input boundary.
    b3.data = 3'b111;
    b3.select = 2'd3; #1;
    chk("c3_oor_out", b3.out, 1'b0);
    chk("c3_oor_err", b3.sel_err, 1'b1);
    b3.select = 2'd2; #1;
    chk("c3_s2_out", b3.out, 1'b1);
    chk("c3_s2_err", b3.sel_err, 1'b0);
    b3.data = 3'b010;
    b3.select = 2'd0; #1; chk("c3b_s0", b3.out, 1'b0);
    b3.select = 2'd1; #1; chk("c3b_s1", b3.out, 1'b1);
    b3.select = 2'd2; #1; chk("c3b_s2", b3.out, 1'b0);

    // Reset and clock have no effect on the combinational path.
    b1.data = 2'b10; b1.select = 1'b1;
    b3.select = 2'd3;
    rst_n = 1'b0; #1;
    chk("c_rst_out1", b1.out, 1'b1);
    chk("c_rst_err3", b3.sel_err, 1'b1);
    @(posedge clk); #1;
    chk("c_rst_clk_out1", b1.out, 1'b1);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
